// File: rtl/fifo_rr_push_arb.sv
// Round-robin push arbiter in front of a FIFO: picks one requester per cycle,
// can lock onto a requester for a multi-beat burst, and sequences a FIFO flush.
module fifo_rr_push_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  input  dtype               req_data_i [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_last_i,
  input  logic               fifo_full_i,
  output logic               fifo_push_o,
  output dtype               fifo_data_o,
  output logic               fifo_flush_o,
  input  logic               flush_req_i,
  output logic               flush_ack_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               locked_o,
  output logic [1:0]         dbg_state_o
);

  // Handshake: a beat moves when req_valid_i[i] && req_ready_o[i]; ready is
  // offered only to the winner (ARB) or the lock owner (LOCK), never while
  // the FIFO is full or a flush is requested, and may depend on valid/full.
  typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_FLUSH, ST_ACK} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_next;
  logic             grant_ok;
  logic             xfer;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      gnt_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      gnt_idx_q  <= gnt_idx_d;
    end
  end

  // Rotating priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_idx  = (state_q == ST_LOCK) ? lock_idx_q : win_idx;
    sel_next = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    // rst_ni gating keeps ready low throughout reset, not just after the edge.
    grant_ok = rst_ni && !fifo_full_i && !flush_req_i &&
               ((state_q == ST_ARB && win_found) || state_q == ST_LOCK);
    xfer     = grant_ok && req_valid_i[sel_idx];
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = grant_ok && (sel_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    gnt_idx_d  = gnt_idx_q;
    case (state_q)
      ST_ARB, ST_LOCK: begin
        if (flush_req_i) begin
          state_d = ST_FLUSH;
        end else if (xfer) begin
          gnt_idx_d = sel_idx;
          if (req_last_i[sel_idx]) begin
            rr_ptr_d = sel_next;
            state_d  = ST_ARB;
          end else begin
            lock_idx_d = sel_idx;
            state_d    = ST_LOCK;
          end
        end
      end
      ST_FLUSH: state_d = ST_ACK;
      ST_ACK: begin
        rr_ptr_d = '0;
        state_d  = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign fifo_push_o  = xfer;
  assign fifo_data_o  = req_data_i[sel_idx];
  assign fifo_flush_o = (state_q == ST_FLUSH);
  assign flush_ack_o  = (state_q == ST_ACK);
  assign locked_o     = (state_q == ST_LOCK);
  assign gnt_idx_o    = gnt_idx_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fifo_rr_push_arb.sv
// Bench for fifo_rr_push_arb: vector table on a 4-requester instance, a wrap
// check on a 3-requester instance, and hand sequences around reset.
module tb_fifo_rr_push_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0]  valid, ready, last;
  logic [31:0] data [4];
  logic        full, flush, push, fflush, ack, locked;
  logic [31:0] fdata;
  logic [1:0]  gnt, st;

  fifo_rr_push_arb #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready), .req_data_i(data),
    .req_last_i(last), .fifo_full_i(full), .fifo_push_o(push),
    .fifo_data_o(fdata), .fifo_flush_o(fflush), .flush_req_i(flush),
    .flush_ack_o(ack), .gnt_idx_o(gnt), .locked_o(locked), .dbg_state_o(st)
  );

  // 3-requester instance
  logic [2:0]  valid3, ready3, last3;
  logic [31:0] data3 [3];
  logic        full3, flush3, push3, fflush3, ack3, locked3;
  logic [31:0] fdata3;
  logic [1:0]  gnt3, st3;

  fifo_rr_push_arb #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid3), .req_ready_o(ready3), .req_data_i(data3),
    .req_last_i(last3), .fifo_full_i(full3), .fifo_push_o(push3),
    .fifo_data_o(fdata3), .fifo_flush_o(fflush3), .flush_req_i(flush3),
    .flush_ack_o(ack3), .gnt_idx_o(gnt3), .locked_o(locked3), .dbg_state_o(st3)
  );

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       flush;
    logic [3:0] exp_ready;
    logic       exp_push;
    logic       exp_fflush;
    logic       exp_ack;
    logic       exp_locked;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                              input logic f, input logic fl,
                              input logic [3:0] er, input logic ep,
                              input logic ef, input logic ea, input logic el,
                              input logic [1:0] eg);
    vec_t r;
    r.valid = v; r.last = l; r.full = f; r.flush = fl;
    r.exp_ready = er; r.exp_push = ep; r.exp_fflush = ef;
    r.exp_ack = ea; r.exp_locked = el; r.exp_gnt = eg;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at negedge, check outputs mid low phase.
  task automatic apply_vec(input vec_t v, input int n);
    logic [31:0] got;
    @(negedge clk);
    valid = v.valid; last = v.last; full = v.full; flush = v.flush;
    for (int i = 0; i < 4; i++) data[i] = $urandom;
    if (v.exp_push)
      for (int i = 0; i < 4; i++) if (v.exp_ready[i]) exp_q.push_back(data[i]);
    #2;
    check($sformatf("v%0d ready", n), ready, v.exp_ready);
    check($sformatf("v%0d push", n), push, v.exp_push);
    check($sformatf("v%0d fifo_flush", n), fflush, v.exp_fflush);
    check($sformatf("v%0d flush_ack", n), ack, v.exp_ack);
    check($sformatf("v%0d locked", n), locked, v.exp_locked);
    check($sformatf("v%0d gnt_idx", n), gnt, v.exp_gnt);
    if (push) begin
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d unexpected_push", n), 1, 0);
      end else begin
        got = exp_q.pop_front();
        check($sformatf("v%0d data", n), fdata, got);
      end
    end
    check($sformatf("v%0d sb_left", n), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int exp3 [4] = '{0, 1, 2, 0};
    int g;
    logic [31:0] got;

    valid = 4'hF; last = 4'hF; full = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    valid3 = '0; last3 = '0; full3 = 1'b0; flush3 = 1'b0;
    for (int i = 0; i < 3; i++) data3[i] = '0;

    // Reset values while valids are asserted.
    #3;
    check("rst ready", ready, 4'b0000);
    check("rst push", push, 0);
    check("rst fifo_flush", fflush, 0);
    check("rst flush_ack", ack, 0);
    check("rst locked", locked, 0);
    check("rst gnt_idx", gnt, 0);
    check("rst ready3", ready3, 3'b000);
    repeat (2) @(negedge clk);
    valid = 4'h0;
    rst_n = 1'b1;

    // Three requesters, all valid and last: rr_ptr must wrap 2 -> 0.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      valid3 = 3'b111; last3 = 3'b111;
      for (int i = 0; i < 3; i++) data3[i] = $urandom;
      g = exp3[c];
      exp_q.push_back(data3[g]);
      #2;
      check($sformatf("n3 c%0d ready", c), ready3, 3'b001 << g);
      check($sformatf("n3 c%0d push", c), push3, 1);
      if (c > 0) check($sformatf("n3 c%0d gnt", c), gnt3, exp3[c-1]);
      got = exp_q.pop_front();
      check($sformatf("n3 c%0d data", c), fdata3, got);
    end
    @(negedge clk);
    valid3 = '0;
    #2;
    check("n3 final gnt", gnt3, 0);
    check("n3 idle push", push3, 0);

    //           valid    last     full  flsh  ready    push  ffl   ack   lock  gnt
    // round robin, all valid
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
    // move rr_ptr to 1, then req1 three-beat burst with req0/req2 valid
    vq.push_back(mk(4'h1, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
    vq.push_back(mk(4'h7, 4'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    vq.push_back(mk(4'h7, 4'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
    vq.push_back(mk(4'h7, 4'h2, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));
    vq.push_back(mk(4'h7, 4'h7, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
    // FIFO full for three cycles, push when it clears
    vq.push_back(mk(4'h1, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    vq.push_back(mk(4'h1, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    vq.push_back(mk(4'h1, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    vq.push_back(mk(4'h1, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
    // lock on req3, owner drops valid, then flush aborts the lock
    vq.push_back(mk(4'h8, 4'h0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    vq.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
    vq.push_back(mk(4'h9, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3));
    vq.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
    // sparse valids skip idle requesters
    vq.push_back(mk(4'hA, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    vq.push_back(mk(4'h0, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
    vq.push_back(mk(4'h9, 4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
    // lock on req1 ahead of the mid-burst reset
    vq.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
    vq.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1));

    for (int n = 0; n < vq.size(); n++) apply_vec(vq[n], n);

    // Asynchronous reset while locked.
    @(negedge clk);
    valid = 4'h7; last = 4'h0; full = 1'b0; flush = 1'b0;
    #1;
    check("prelock locked", locked, 1);
    rst_n = 1'b0;
    #1;
    check("arst ready", ready, 4'b0000);
    check("arst push", push, 0);
    check("arst locked", locked, 0);
    check("arst gnt_idx", gnt, 0);
    check("arst fifo_flush", fflush, 0);
    check("arst flush_ack", ack, 0);
    @(negedge clk);
    valid = 4'h0;
    rst_n = 1'b1;
    apply_vec(mk(4'h4, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), 100);
    apply_vec(mk(4'h0, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), 101);

    // After a reset the scan restarts at index 0 even though rr_ptr was 3.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(mk(4'hA, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), 102);
    apply_vec(mk(4'h0, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1), 103);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rr_push_arb.md
FIFO_RR_PUSH_ARB -- requirements
Module: fifo_rr_push_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of push requesters (legal 1..64).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width used by the default dtype.
REQ-003 The block SHALL have parameter dtype, default logic [DATA_WIDTH-1:0], giving the payload type.
REQ-004 The block SHALL derive IDX_W = max(1, clog2(NUM_REQ)).
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester push valid.
REQ-008 req_ready_o  out  NUM_REQ  per-requester push accept.
REQ-009 req_data_i  in  NUM_REQ x dtype  per-requester payload.
REQ-010 req_last_i  in  NUM_REQ  final beat of a burst; 0 requests a grant lock.
REQ-011 fifo_full_i  in  1  full flag of the downstream FIFO.
REQ-012 fifo_push_o  out  1  push strobe to the FIFO.
REQ-013 fifo_data_o  out  dtype  payload to the FIFO.
REQ-014 fifo_flush_o  out  1  flush strobe to the FIFO.
REQ-015 flush_req_i  in  1  level request to flush the FIFO.
REQ-016 flush_ack_o  out  1  one-cycle flush-complete pulse.
REQ-017 gnt_idx_o  out  IDX_W  index of the current or last granted requester.
REQ-018 locked_o  out  1  high while in LOCK.

Function
REQ-019 The block SHALL implement an FSM with states ARB, LOCK, FLUSH and ACK.
REQ-020 ARB: winner = first i with req_valid_i[i]=1, scanning from rr_ptr upward modulo NUM_REQ; req_ready_o[winner] = !fifo_full_i && !flush_req_i; all other ready bits 0.
REQ-021 LOCK: only lock owner lock_idx is eligible; req_ready_o[lock_idx] = !fifo_full_i && !flush_req_i; all other ready bits 0.
REQ-022 A beat SHALL transfer when req_valid_i[i] && req_ready_o[i], where i is the winner in ARB or lock_idx in LOCK; combinational paths from valid/full to ready are permitted.
REQ-023 On a transfer: fifo_push_o=1 in the same cycle, fifo_data_o=req_data_i[i], gnt_idx_o<=i; zero added latency.
REQ-024 fifo_push_o SHALL never assert while fifo_full_i=1; fifo_data_o is don't-care when fifo_push_o=0.
REQ-025 Transfer with req_last_i[i]=1: rr_ptr <= (i+1) mod NUM_REQ; next state ARB.
REQ-026 Transfer with req_last_i[i]=0: lock_idx <= i; rr_ptr unchanged; next state LOCK.
REQ-027 In LOCK, deassertion of the owner's valid SHALL NOT release the lock; only a last beat (to ARB) or a flush (to FLUSH) leaves LOCK.
REQ-028 flush_req_i=1 in ARB or LOCK SHALL block all transfers that cycle (no ready, no push) and move to FLUSH; it aborts any lock.
REQ-029 FLUSH: fifo_flush_o=1 for exactly one cycle; all ready bits 0; next state ACK.
REQ-030 ACK: flush_ack_o=1 for exactly one cycle; all ready bits 0; rr_ptr<=0; next state ARB; flush_req_i is ignored in FLUSH and ACK and resampled in ARB.
REQ-031 NUM_REQ=1: rr_ptr and the winner are constantly 0; LOCK behaviour is unchanged.
REQ-032 rr_ptr wrap SHALL be modulo NUM_REQ, including when NUM_REQ is not a power of two.

Reset
REQ-033 While rst_ni=0: state=ARB, rr_ptr=0, lock_idx=0, gnt_idx_o=0, locked_o=0, fifo_push_o=0, fifo_flush_o=0, flush_ack_o=0, all req_ready_o=0.
REQ-034 Reset asserted mid-burst SHALL discard the lock with no pending flush; the first post-reset grant starts scanning at index 0.

Verification
REQ-035 NUM_REQ=4, all valid, all last=1, full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3; one push per cycle.
REQ-036 Req1 sends 3 beats with last=0,0,1 while req0 and req2 stay valid -> grants 1,1,1, then 2; locked_o=1 during beats 2-3.
REQ-037 fifo_full_i=1 for 3 cycles with req0 valid -> no push and req_ready_o=0; push occurs in the cycle full returns to 0.
REQ-038 flush_req_i during LOCK on req3 -> no push that cycle; fifo_flush_o pulse next cycle, flush_ack_o the cycle after; next grant comes from index 0.
REQ-039 NUM_REQ=3, all valid with last=1 -> grants 0,1,2,0, confirming rr_ptr wraps from 2 to 0.
REQ-040 rst_ni low during LOCK -> outputs at reset values immediately (asynchronous); after release, an idle cycle with req2 only valid gives grant 2 in ARB.
